// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell built from two half-adders,
// reused across WIDTH bits, one bit per clock, behind a start/busy/done handshake.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] op_a, op_b, res, res_shift;
    logic [CW-1:0]    cnt;
    logic             cflop;
    logic             hs1, hc1, hc2, bit_s, carry_next;
    logic             last_bit;

    // The shared full-adder cell: two half-adder stages and a carry OR.
    always_comb begin
        hs1        = op_a[0] ^ op_b[0];
        hc1        = op_a[0] & op_b[0];
        bit_s      = hs1 ^ cflop;
        hc2        = hs1 & cflop;
        carry_next = hc1 | hc2;
        res_shift  = res >> 1;
        res_shift[WIDTH-1] = bit_s;
        last_bit   = (cnt == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ADD;
                end
            end
            ADD: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // sum/carry are only written on the final ADD edge, so partial results never leak out.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            cnt   <= '0;
            cflop <= 1'b0;
            sum   <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        res   <= '0;
                        cnt   <= '0;
                        cflop <= 1'b0;
                    end
                end
                ADD: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    res   <= res_shift;
                    cflop <= carry_next;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        sum   <= res_shift;
                        carry <= carry_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder controller. It time-shares a single 1-bit full-adder cell (two half-adder stages plus a carry OR) across the WIDTH bits of two operands, one bit per clock. A start/busy/done handshake makes it a drop-in sequencer wherever area matters more than latency. The added-result output and carry output mirror the half-adder sum/carry semantics, extended to WIDTH bits.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high; sampled on the rising edge of clk.
start  input  1  request to add; accepted only in IDLE.
a  input  WIDTH  operand A; sampled only on the accepting edge.
b  input  WIDTH  operand B; sampled only on the accepting edge.
busy  output  1  high while bits are being processed (ADD state).
done  output  1  one-cycle pulse; sum/carry valid from this cycle onward.
sum  output  WIDTH  result a+b modulo 2^WIDTH; held until the next completion.
carry  output  1  carry-out of the MSB; held with sum.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, carry=0. Internal operand shift registers, result shift register, carry flop and bit counter are all cleared.
- FSM states are IDLE, ADD and DONE.
- IDLE to ADD: on an edge with start=1.
  - Load a and b into the operand shift registers.
  - Clear the carry flop and bit counter (counter width = clog2(WIDTH+1)).
- ADD, each edge:
  - hs1 = opA[0]^opB[0], hc1 = opA[0]&opB[0].
  - bit = hs1^cflop, hc2 = hs1&cflop.
  - cflop <= hc1|hc2.
  - The result register shifts right with bit entering at the MSB.
  - opA and opB shift right, and the counter increments.
- ADD to DONE: on the edge where the counter reaches WIDTH-1 (the last bit is processed on that same edge).
  - sum <= final result register value (including the last bit).
  - carry <= final carry.
- DONE to IDLE: unconditionally on the next edge.
- Outputs:
  - busy = (state==ADD).
  - done = (state==DONE); it is exactly one cycle wide.
- Latency: start is sampled at edge k. busy is high for edges k+1..k+WIDTH. done is high in the cycle following edge k+WIDTH. Minimum start-to-start period is WIDTH+2 edges.
- sum/carry never show partial results. They change only on the ADD to DONE edge (or reset) and hold indefinitely afterwards.
- start while in ADD or DONE: ignored, with no queuing. Changes to a/b after acceptance have no effect.
- start held high continuously: a new operation is accepted on the first edge spent in IDLE after DONE.
- WIDTH=1: a single ADD cycle. sum = a^b, carry = a&b (pure half-adder behaviour).
- Reset mid-operation: rst at any edge overrides everything.
  - Return to IDLE and clear sum/carry to 0.
  - No done pulse is produced for the aborted operation.
- rst and start on the same edge: reset wins and start is not accepted.

Test Plan:
- WIDTH=8, reset then a=0x00, b=0x00, start pulse.
  - Expect busy high for exactly 8 cycles, then done high for 1 cycle.
  - Expect sum=0x00, carry=0.
  - Expect busy=0, done=0, sum=0, carry=0 while rst=1.
- WIDTH=8 operand sweep:
  - 0xFF+0x01 gives sum=0x00, carry=1.
  - 0xA5+0x5A gives sum=0xFF, carry=0.
  - 0xFF+0xFF gives sum=0xFE, carry=1.
  - 0x80+0x80 gives sum=0x00, carry=1.
- Start 0x12+0x34; during busy, pulse start again and change a/b to 0xFF/0xFF.
  - Expect a single done, sum=0x46, carry=0.
  - Expect sum/carry to be unchanged before done.
- Start 0xF0+0x0F, assert rst for 1 cycle after the 4th busy cycle.
  - Expect busy=0 the next cycle, no done, sum=0x00, carry=0.
  - A subsequent start of 0x01+0x01 gives sum=0x02.
- Hold start high continuously with operands 0x10+0x20.
  - Expect done pulses exactly every 10 cycles.
  - Expect sum=0x30 to hold between pulses.
- WIDTH=4 (and WIDTH=1) exhaustive: all a,b pairs checked against {carry,sum} == a+b.
  - WIDTH=1 must match the half-adder truth table:
    - 00 gives 0/0.
    - 01 gives 1/0.
    - 10 gives 1/0.
    - 11 gives 0/1.
